// File: rtl/obuffer_col_pkg.sv
// Shared array-column constants and types used by the column buffers.
// The output column buffer takes its widths and FSM encoding from here.
package obuffer_col_pkg;
  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = BYTE_W * LANES;
  localparam int ASM_W  = WORD_W - BYTE_W;
  localparam int CNT_W  = 2;

  // Input column buffer: one word in, LANES serial bytes out, small skid depth.
  localparam int IBUF_LANES = LANES;
  localparam int IBUF_DEPTH = 2;

  typedef enum logic [0:0] {
    COLLECT    = 1'b0,
    FLUSH_WAIT = 1'b1
  } obuf_state_t;

  // Partial word: assembled lanes followed by a zero lowest lane.
  function automatic logic [WORD_W-1:0] pad_partial(input logic [ASM_W-1:0] asm);
    return {asm, {BYTE_W{1'b0}}};
  endfunction
endpackage

// File: rtl/obuffer_col_if.sv
// Byte-in / word-out port bundle of one output column buffer.
// Handshake: a byte moves on an edge with ShiftEN && IReady; a word is consumed on an edge with ReadEN && OValid.
interface obuffer_col_if;
  import obuffer_col_pkg::*;

  logic              ShiftEN;
  logic [BYTE_W-1:0] ID;
  logic              Flush;
  logic              ReadEN;
  logic              IReady;
  logic [WORD_W-1:0] OWord;
  logic              OValid;
  logic              Overflow;

  modport master (
    output ShiftEN, ID, Flush, ReadEN,
    input  IReady, OWord, OValid, Overflow
  );

  modport slave (
    input  ShiftEN, ID, Flush, ReadEN,
    output IReady, OWord, OValid, Overflow
  );
endinterface

// File: rtl/obuffer_col.sv
// Output column buffer: packs serial result bytes from one array column into
// 32-bit words, first byte in the most significant lane, with flush of partial words.
module obuffer_col
  import obuffer_col_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  obuffer_col_if.slave     bus,
  output obuf_state_t      state_dbg,
  output logic [CNT_W-1:0] cnt_dbg
);

  obuf_state_t       state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [ASM_W-1:0]  asm_q, asm_n;
  logic [WORD_W-1:0] word_q, word_n;
  logic              valid_q, valid_n;
  logic              ovf_q, ovf_n;

  logic              ready;
  logic              accept;
  logic              out_free;
  logic              load;
  logic [WORD_W-1:0] load_word;

  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  // Stall only when the last byte would need an output slot that stays occupied.
  assign ready    = (state_q == COLLECT) &&
                    !((cnt_q == LAST_LANE) && valid_q && !bus.ReadEN);
  assign accept   = bus.ShiftEN && ready;
  assign out_free = !valid_q || bus.ReadEN;

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    asm_n     = asm_q;
    word_n    = word_q;
    valid_n   = valid_q;
    ovf_n     = ovf_q;
    load      = 1'b0;
    load_word = '0;

    if (bus.ShiftEN && !ready) ovf_n = 1'b1;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (cnt_q == LAST_LANE) begin
            load      = 1'b1;
            load_word = {asm_q, bus.ID};
            asm_n     = '0;
            cnt_n     = '0;
          end else begin
            for (int i = 0; i < LANES - 1; i++) begin
              if (cnt_q == CNT_W'(i)) asm_n[ASM_W-1-i*BYTE_W -: BYTE_W] = bus.ID;
            end
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        // Flush sees the count after this edge's byte; a just-completed word leaves nothing to flush.
        if (bus.Flush && (cnt_n != '0)) begin
          if (out_free) begin
            load      = 1'b1;
            load_word = pad_partial(asm_n);
            asm_n     = '0;
            cnt_n     = '0;
          end else begin
            state_n = FLUSH_WAIT;
          end
        end
      end
      FLUSH_WAIT: begin
        if (bus.ReadEN && valid_q) begin
          load      = 1'b1;
          load_word = pad_partial(asm_q);
          asm_n     = '0;
          cnt_n     = '0;
          state_n   = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase

    if (load) begin
      word_n  = load_word;
      valid_n = 1'b1;
    end else if (bus.ReadEN && valid_q) begin
      valid_n = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      asm_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      asm_q   <= asm_n;
      word_q  <= word_n;
      valid_q <= valid_n;
      ovf_q   <= ovf_n;
    end
  end

  assign bus.IReady   = ready;
  assign bus.OWord    = word_q;
  assign bus.OValid   = valid_q;
  assign bus.Overflow = ovf_q;
  assign state_dbg    = state_q;
  assign cnt_dbg      = cnt_q;

endmodule
